alu_wb_stage: RTL
=================

ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of result-buffer entries (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 32, width of retire counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 i_valid  input  1  ALU stage result valid this cycle.
REQ-006 i_alu_result  input  32  ALU result.
REQ-007 i_rd  input  5  destination register index.
REQ-008 i_rd_we  input  1  instruction writes rd.
REQ-009 i_flush  input  1  flush from branch/exception; kills the incoming result only.
REQ-010 o_stall  output  1  buffer full; upstream ALU stage holds.
REQ-011 o_rf_we  output  1  register-file write request/enable.
REQ-012 o_rf_waddr  output  5  write address.
REQ-013 o_rf_wdata  output  32  write data.
REQ-014 i_rf_grant  input  1  shared write port granted this cycle.
REQ-015 i_byp_rs  input  5  bypass lookup source register.
REQ-016 o_byp_hit  output  1  lookup matched a buffered result.
REQ-017 o_byp_data  output  32  matched result data.
REQ-018 o_retire  output  1  one-cycle pulse per instruction leaving the stage.
REQ-019 o_retire_cnt  output  CNT_W  count of retired instructions.

Function
REQ-020 Circular buffer of DEPTH entries {rd, wr, data}, wr = i_rd_we && (i_rd != 0); read/write pointers wrap modulo DEPTH; occupancy count 0..DEPTH.
REQ-021 o_stall SHALL equal (count == DEPTH), derived from registered count only (no combinational path from inputs).
REQ-022 Enqueue when i_valid && !i_flush && !o_stall; entry written at write pointer, pointer advances.
REQ-023 i_valid while o_stall: input not captured (upstream holds it); i_valid with i_flush: input discarded, no state change from it.
REQ-024 i_flush SHALL NOT affect buffered entries (they are older than the flushed instruction and are committed).
REQ-025 o_rf_we = (count != 0) && head.wr; o_rf_waddr/o_rf_wdata = head rd/data when head valid, else 0.
REQ-026 Dequeue when count != 0 && (!head.wr || i_rf_grant); non-writing heads dequeue without grant.
REQ-027 Head with o_rf_we high and i_rf_grant low SHALL hold unchanged until granted.
REQ-028 Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
REQ-029 Enqueue-to-o_rf_we latency: 1 cycle when buffer empty; throughput 1 instruction/cycle with continuous grant.
REQ-030 o_retire = dequeue condition (combinational, same cycle); o_retire_cnt increments by 1 on each dequeue, wraps at 2^CNT_W.
REQ-031 Bypass: o_byp_hit high when i_byp_rs != 0 and some valid entry has wr && rd == i_byp_rs; o_byp_data = data of the youngest such entry, else 0.
REQ-032 Bypass SHALL consider only buffered entries, not the same-cycle input; an entry being dequeued this cycle still participates.

Reset
REQ-033 rst high at a clock edge: count, pointers, o_retire_cnt cleared to 0; buffer contents do not care.
REQ-034 While count == 0 after reset: o_stall, o_rf_we, o_byp_hit, o_retire = 0; o_rf_waddr, o_rf_wdata, o_byp_data = 0.
REQ-035 rst mid-operation SHALL discard all buffered entries without issuing writes; rst has priority over enqueue, dequeue and flush.

Verification
REQ-036 Empty, grant=1: i_valid, rd=5, we=1, result=0xDEADBEEF -> next cycle o_rf_we=1, waddr=5, wdata=0xDEADBEEF, o_retire=1, o_retire_cnt 0->1.
REQ-037 grant=0, three back-to-back writes rd=1,2,3 -> o_stall=1 after second accept, third held; raise grant -> writes 1,2,3 in order, o_stall drops after first write.
REQ-038 rd=0 we=1 and rd=7 we=0 with grant=0 -> both retire in consecutive cycles, o_rf_we never 1, o_retire_cnt +2.
REQ-039 grant=0, buffer rd=4/0x11 then rd=4/0x22; i_byp_rs=4 -> hit=1, data=0x22; i_byp_rs=0 -> hit=0.
REQ-040 i_valid with i_flush=1 -> not captured; buffered entry still written on grant. rst asserted with 2 entries -> next cycle count 0, o_rf_we=0, o_retire_cnt=0.

Source files
------------

// File: rtl/alu_wb_stage_if.sv
// ALU-to-writeback result handshake.
// Master is the ALU stage; slave is the writeback buffer.
interface alu_wb_stage_if;
    logic        i_valid;
    logic [31:0] i_alu_result;
    logic [4:0]  i_rd;
    logic        i_rd_we;
    logic        i_flush;
    logic        o_stall;

    modport master (
        output i_valid,
        output i_alu_result,
        output i_rd,
        output i_rd_we,
        output i_flush,
        input  o_stall
    );

    modport slave (
        input  i_valid,
        input  i_alu_result,
        input  i_rd,
        input  i_rd_we,
        input  i_flush,
        output o_stall
    );
endinterface

// File: rtl/alu_wb_stage.sv
// Writeback stage: circular result buffer feeding a shared
// register-file write port, with bypass lookup and retire count.
module alu_wb_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    alu_wb_stage_if.slave    up,
    output logic             o_rf_we,
    output logic [4:0]       o_rf_waddr,
    output logic [31:0]      o_rf_wdata,
    input  logic             i_rf_grant,
    input  logic [4:0]       i_byp_rs,
    output logic             o_byp_hit,
    output logic [31:0]      o_byp_data,
    output logic             o_retire,
    output logic [CNT_W-1:0] o_retire_cnt
);

    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [4:0]       rd_q   [DEPTH];
    logic             wr_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    logic             full;
    logic             nonempty;
    logic             enq;
    logic             deq;
    logic             head_wr;
    logic [PW-1:0]    idx;

    assign full     = (count_q == CW'(DEPTH));
    assign nonempty = (count_q != '0);
    assign head_wr  = wr_q[rd_ptr_q];

    assign up.o_stall = full;

    assign enq = up.i_valid && !up.i_flush && !full;
    assign deq = nonempty && (!head_wr || i_rf_grant);

    assign o_rf_we    = nonempty && head_wr;
    assign o_rf_waddr = nonempty ? rd_q[rd_ptr_q] : 5'd0;
    assign o_rf_wdata = nonempty ? data_q[rd_ptr_q] : 32'd0;
    assign o_retire   = deq;
    assign o_retire_cnt = retire_cnt_q;

    // Pointer, occupancy and retire-counter next state.
    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        retire_cnt_d = retire_cnt_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (deq) begin
            rd_ptr_d     = rd_ptr_q + PW'(1);
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
        unique case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset drops all entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Entry storage; contents only matter once counted valid.
    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            rd_q[wr_ptr_q]   <= up.i_rd;
            wr_q[wr_ptr_q]   <= up.i_rd_we && (up.i_rd != 5'd0);
            data_q[wr_ptr_q] <= up.i_alu_result;
        end
    end

    // Bypass: scan oldest to youngest so the youngest match wins.
    always_comb begin
        o_byp_hit  = 1'b0;
        o_byp_data = 32'd0;
        idx        = rd_ptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if ((CW'(k) < count_q) && wr_q[idx] &&
                (rd_q[idx] == i_byp_rs) && (i_byp_rs != 5'd0)) begin
                o_byp_hit  = 1'b1;
                o_byp_data = data_q[idx];
            end
        end
    end

endmodule
